// File: rtl/ram_arbiter_llsc.sv
// Single-port RAM arbiter between instruction fetch and data access.
// One transaction is granted at a time, with priority alternating when both
// ports request. Also holds the LL/SC reservation and resolves SC
// success/failure without touching the RAM on failure.
module ram_arbiter_llsc #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          iREN,
   input  logic [AW-1:0] iaddr,
   output logic [DW-1:0] iload,
   output logic          iwait,
   input  logic          dREN,
   input  logic          dWEN,
   input  logic          dLL,
   input  logic          dSC,
   input  logic [AW-1:0] daddr,
   input  logic [DW-1:0] dstore,
   output logic [DW-1:0] dload,
   output logic          dwait,
   output logic          ramREN,
   output logic          ramWEN,
   output logic [AW-1:0] ramaddr,
   output logic [DW-1:0] ramstore,
   input  logic [DW-1:0] ramload,
   input  logic [1:0]    ramstate,
   output logic          link_valid
);

   typedef enum logic [1:0] {IDLE, ISERVE, DSERVE, SCFAIL} state_t;
   typedef enum logic [1:0] {RS_FREE, RS_BUSY, RS_ACCESS, RS_ERROR} ramstate_t;

   state_t        state_q, state_d;
   logic          last_d_q, last_d_d;
   logic          link_valid_q, link_valid_d;
   logic [AW-1:0] link_addr_q, link_addr_d;

   logic          d_req;
   logic          ram_done;
   logic          sc_match;
   state_t        d_target;

   assign link_valid = link_valid_q;

   // State, priority and reservation registers; reset drops the RAM enables at once.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         last_d_q     <= 1'b0;
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_d_q     <= last_d_d;
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
      end
   end

   // Arbitration, RAM drive, completion handshakes and reservation update.
   always_comb begin
      state_d      = state_q;
      last_d_d     = last_d_q;
      link_valid_d = link_valid_q;
      link_addr_d  = link_addr_q;
      ramREN       = 1'b0;
      ramWEN       = 1'b0;
      ramaddr      = '0;
      ramstore     = '0;
      iwait        = 1'b1;
      dwait        = 1'b1;
      iload        = '0;
      dload        = '0;

      d_req    = dREN | dWEN;
      ram_done = (ramstate == RS_ACCESS);
      sc_match = link_valid_q && (link_addr_q == daddr);
      // An SC that cannot succeed is resolved without a RAM access.
      d_target = (dWEN && dSC && !sc_match) ? SCFAIL : DSERVE;

      unique case (state_q)
         IDLE: begin
            if (iREN && d_req)
               state_d = last_d_q ? ISERVE : d_target;
            else if (d_req)
               state_d = d_target;
            else if (iREN)
               state_d = ISERVE;
         end

         ISERVE: begin
            if (!iREN) begin
               state_d = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ram_done) begin
                  iwait    = 1'b0;
                  iload    = ramload;
                  last_d_d = 1'b0;
                  state_d  = IDLE;
               end
            end
         end

         DSERVE: begin
            if (!d_req) begin
               state_d = IDLE;
            end else begin
               // A simultaneous read and write is treated as the write alone.
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (ram_done) begin
                  dwait    = 1'b0;
                  last_d_d = 1'b1;
                  state_d  = IDLE;
                  if (dWEN) begin
                     dload = dSC ? DW'(1) : '0;
                     if (dSC || (daddr == link_addr_q))
                        link_valid_d = 1'b0;
                  end else begin
                     dload = ramload;
                     if (dLL) begin
                        link_valid_d = 1'b1;
                        link_addr_d  = daddr;
                     end
                  end
               end
            end
         end

         SCFAIL: begin
            dwait        = 1'b0;
            last_d_d     = 1'b1;
            link_valid_d = 1'b0;
            state_d      = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram_arbiter_llsc.sv
// Bench for ram_arbiter_llsc: directed scenarios plus randomized transactions,
// checked against a transaction-level model of grants, memory and reservation.
module tb_ram_arbiter_llsc;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;
   localparam int OP_LW = 0, OP_SW = 1, OP_LL = 2, OP_SC = 3;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          iREN, dREN, dWEN, dLL, dSC;
   logic [AW-1:0] iaddr, daddr, ramaddr;
   logic [DW-1:0] iload, dload, dstore, ramstore, ramload;
   logic          iwait, dwait, ramREN, ramWEN, link_valid;
   logic [1:0]    ramstate;

   always #5 CLK = ~CLK;

   ram_arbiter_llsc #(.AW(AW), .DW(DW)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .dLL(dLL), .dSC(dSC), .daddr(daddr),
      .dstore(dstore), .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .link_valid(link_valid)
   );

   int unsigned n_chk = 0, n_pass = 0, n_fail = 0;

   // Reference model: memory contents, last port served, reservation.
   logic [31:0] mem [logic [31:0]];
   bit          m_last_d;
   bit          m_resv;
   logic [31:0] m_raddr;
   bit          g_both;            // SW issued with dREN also high
   logic [1:0]  rs_q [$];          // forced ramstate sequence for the next serve

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : ~a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit pi, input logic [31:0] ia, input bit pd, input int op,
                        input logic [31:0] da, input logic [31:0] ds);
      iREN   = pi;
      iaddr  = ia;
      dREN   = pd && (op == OP_LW || op == OP_LL || (op == OP_SW && g_both));
      dWEN   = pd && (op == OP_SW || op == OP_SC);
      dLL    = pd && (op == OP_LL);
      dSC    = pd && (op == OP_SC);
      daddr  = da;
      dstore = ds;
   endtask

   // Runs an optional fetch and an optional data op to completion, starting at a negedge.
   task automatic run(input bit di, input logic [31:0] ia, input bit dd, input int op,
                      input logic [31:0] da, input logic [31:0] ds);
      bit pi = di, pd = dd, srv_d, done, is_wr;
      logic [1:0] rs;
      int budget;
      is_wr = (op == OP_SW || op == OP_SC);
      while (pi || pd) begin
         drive(pi, ia, pd, op, da, ds);
         #1 ramstate = FREE; ramload = rd(ramaddr);
         #1;
         chk("idle_ramREN", ramREN, 0);
         chk("idle_ramWEN", ramWEN, 0);
         chk("idle_iwait", iwait, 1);
         chk("idle_dwait", dwait, 1);
         chk("idle_link", link_valid, m_resv);
         srv_d = pd && (!pi || !m_last_d);
         @(negedge CLK);
         if (srv_d && op == OP_SC && !(m_resv && m_raddr == da)) begin
            drive(pi, ia, pd, op, da, ds);
            #1 ramstate = FREE; ramload = rd(ramaddr);
            #1;
            chk("scf_dwait", dwait, 0);
            chk("scf_dload", dload, 0);
            chk("scf_ramWEN", ramWEN, 0);
            chk("scf_ramREN", ramREN, 0);
            chk("scf_iwait", iwait, 1);
            m_resv = 0; m_last_d = 1; pd = 0;
            @(negedge CLK);
            continue;
         end
         done = 0; budget = 0;
         while (!done) begin
            drive(pi, ia, pd, op, da, ds);
            if (rs_q.size() > 0) rs = rs_q.pop_front();
            else if ($urandom_range(1, 0) == 1) rs = ACC;
            else rs = 2'($urandom_range(3, 0));
            if (budget >= 20) rs = ACC;
            budget++;
            #1 ramstate = rs; ramload = rd(ramaddr);
            #1;
            chk("srv_addr", ramaddr, srv_d ? da : ia);
            chk("srv_ramREN", ramREN, srv_d ? !is_wr : 1'b1);
            chk("srv_ramWEN", ramWEN, srv_d && is_wr);
            if (srv_d && is_wr) chk("srv_store", ramstore, ds);
            chk("srv_iwait", iwait, !(!srv_d && rs == ACC));
            chk("srv_dwait", dwait, !(srv_d && rs == ACC));
            chk("srv_link", link_valid, m_resv);
            if (rs == ACC) begin
               if (!srv_d) begin
                  chk("iload", iload, rd(ia));
                  pi = 0;
               end else begin
                  if (!is_wr) chk("dload_rd", dload, rd(da));
                  if (op == OP_SC) chk("dload_sc", dload, 1);
                  if (is_wr) mem[da] = ds;
                  if (op == OP_LL) begin m_resv = 1; m_raddr = da; end
                  if (op == OP_SC || (is_wr && da == m_raddr)) m_resv = 0;
                  pd = 0;
               end
               m_last_d = srv_d;
               done = 1;
            end
            @(negedge CLK);
         end
      end
      drive(0, 0, 0, OP_LW, 0, 0);
   endtask

   initial begin
      logic [31:0] addrs [4];
      addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h200; addrs[3] = 32'h40;
      m_last_d = 0; m_resv = 0; m_raddr = '0; g_both = 0;
      nRST = 1'b0; ramstate = FREE; ramload = '0;
      drive(0, 0, 0, OP_LW, 0, 0);
      #3;
      chk("rst_ramREN", ramREN, 0);
      chk("rst_ramWEN", ramWEN, 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_ramstore", ramstore, 0);
      chk("rst_iwait", iwait, 1);
      chk("rst_dwait", dwait, 1);
      chk("rst_iload", iload, 0);
      chk("rst_dload", dload, 0);
      chk("rst_link", link_valid, 0);
      @(negedge CLK); @(negedge CLK);
      nRST = 1'b1;

      // Fetch with two BUSY cycles before ACCESS.
      mem[32'h40] = 32'h8C22_0004;
      rs_q = '{BUSY, BUSY, ACC};
      run(1, 32'h40, 0, OP_LW, 0, 0);

      // Both ports held: data wins first after reset, then alternation.
      rs_q = '{ACC, ACC, ACC, ACC};
      run(1, 32'h40, 1, OP_LW, 32'h200, 0);
      run(1, 32'h40, 1, OP_LW, 32'h104, 0);

      // LL then successful SC.
      run(0, 0, 1, OP_LL, 32'h100, 0);
      chk("ll_link", link_valid, 1);
      run(0, 0, 1, OP_SC, 32'h100, 32'hABCD);
      chk("sc_link", link_valid, 0);

      // LL, SW to same address, SC fails.
      run(0, 0, 1, OP_LL, 32'h100, 0);
      run(0, 0, 1, OP_SW, 32'h100, 32'h1234);
      chk("sw_clears_link", link_valid, 0);
      run(0, 0, 1, OP_SC, 32'h100, 32'h5678);
      chk("scfail_mem_kept", rd(32'h100), 32'h1234);

      // ERROR retries on a data write, with dREN also high.
      g_both = 1;
      rs_q = '{ERR, ERR, ERR, ACC};
      run(0, 0, 1, OP_SW, 32'h200, 32'hCAFE_F00D);
      g_both = 0;

      // Data request dropped mid-serve: no completion, priority unchanged.
      drive(0, 0, 1, OP_LW, 32'h104, 0);
      #1 ramstate = FREE; #1;
      @(negedge CLK);
      drive(0, 0, 0, OP_LW, 32'h104, 0);
      #1 ramstate = ACC; #1;
      chk("drop_ramREN", ramREN, 0);
      chk("drop_dwait", dwait, 1);
      @(negedge CLK);
      run(1, 32'h40, 1, OP_LW, 32'h200, 0);

      // Reset in the middle of a data write drops enables and reservation.
      run(0, 0, 1, OP_LL, 32'h300, 0);
      drive(0, 0, 1, OP_SW, 32'h304, 32'h55);
      #1 ramstate = FREE; #1;
      @(negedge CLK);
      #1 ramstate = BUSY; #1;
      chk("pre_rst_ramWEN", ramWEN, 1);
      nRST = 1'b0;
      #1;
      chk("mid_rst_ramWEN", ramWEN, 0);
      chk("mid_rst_ramREN", ramREN, 0);
      chk("mid_rst_link", link_valid, 0);
      chk("mid_rst_dwait", dwait, 1);
      drive(0, 0, 0, OP_LW, 0, 0);
      @(negedge CLK);
      nRST = 1'b1;
      m_resv = 0; m_last_d = 0;

      // Randomized mix of fetches and data operations.
      for (int k = 0; k < 80; k++) begin
         bit di, dd;
         int op;
         di = 1'($urandom_range(1, 0));
         dd = 1'($urandom_range(1, 0));
         if (!di && !dd) dd = 1;
         op = $urandom_range(3, 0);
         g_both = 1'($urandom_range(1, 0));
         run(di, addrs[$urandom_range(3, 0)], dd, op, addrs[$urandom_range(3, 0)], $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ram_arbiter_llsc.md
Name: ram_arbiter_llsc

Overview:
Single-port RAM arbiter between the fetch port (instruction reads) and the data port (LW/SW/LL/SC) of the MIPS core. It holds one registered grant per transaction and alternates priority so neither port starves. It also owns the LL/SC reservation register, so it decides SC success and suppresses the RAM write when SC fails. It sits between the caches/datapath and the RAM model and takes dREN/dWEN qualifiers straight from the control unit.

Parameters:
AW, 32, address width in bits (byte address)
DW, 32, data width in bits

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request
iaddr  in  AW  instruction address
iload  out  DW  instruction read data, valid when iwait=0
iwait  out  1  1 = fetch not complete this cycle
dREN  in  1  data read request (LW/LL)
dWEN  in  1  data write request (SW/SC)
dLL  in  1  qualifies dREN as LL
dSC  in  1  qualifies dWEN as SC
daddr  in  AW  data address
dstore  in  DW  write data
dload  out  DW  read data, or SC result (1/0), valid when dwait=0
dwait  out  1  1 = data access not complete this cycle
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  AW  RAM address
ramstore  out  DW  RAM write data
ramload  in  DW  RAM read data
ramstate  in  2  00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
link_valid  out  1  reservation held (debug/verification visibility)

Behaviour:
- One clock; reset asynchronous active-low, as decided. On reset: state IDLE, last_d=0, link_valid=0, link_addr=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
- States: IDLE, ISERVE, DSERVE, SCFAIL.
- IDLE: RAM enables 0. Next state: both ports requesting -> DSERVE if last_d=0, else ISERVE. Only dREN|dWEN -> DSERVE, except SC with no matching reservation -> SCFAIL. Only iREN -> ISERVE. Same rules for SC when data wins arbitration.
- ISERVE: ramREN=1, ramaddr=iaddr. When ramstate=ACCESS: iwait=0, iload=ramload in the same cycle, last_d<=0, go to IDLE.
- DSERVE: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore. When ramstate=ACCESS: dwait=0, dload=ramload on reads, dload=1 on SC, last_d<=1, go to IDLE.
- SCFAIL: no RAM enables. dwait=0 and dload=0 for one cycle. last_d<=1, go to IDLE.
- Minimum latency: 2 cycles from request to completion (IDLE cycle + ACCESS cycle). All other waits are ramstate-driven.
- ramstate BUSY/FREE while serving: hold state and RAM outputs, wait stays 1. ERROR: the same, and the request is reissued unchanged.
- Requester drops its request while being served (iREN=0 in ISERVE, or dREN=dWEN=0 in DSERVE): RAM enables go 0 that cycle, return to IDLE, no completion pulse, last_d unchanged.
- dREN and dWEN both high: treated as a write, with the read ignored.
- Reservation:
  - LL completion: link_valid<=1, link_addr<=daddr.
  - SC completion (success or fail): link_valid<=0.
  - Plain SW completion with daddr==link_addr: link_valid<=0.
  - Address compare is on the full AW bits.
  - LL and SC matching checks use registered link state at the cycle of arbitration.
- Reset mid-transaction: immediate IDLE, enables 0, reservation lost. The RAM sees the enables drop asynchronously.
- iwait/dwait are combinational from state and ramstate. Wait for a port not being served is 1.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, ramstate ACCESS after 2 BUSY cycles, ramload=0x8C220004 -> ramREN high 3 cycles, single iwait=0 pulse with iload=0x8C220004, ramWEN never high.
- iREN and dREN both held, RAM returns ACCESS each serve cycle -> grants alternate D,I,D,I after reset (last_d=0 gives data first). No port waits more than one peer access.
- LL 0x100 then SC 0x100, dstore=0xABCD -> SC drives ramWEN=1, ramaddr=0x100, ramstore=0xABCD; dload=1; link_valid returns to 0.
- LL 0x100, SW 0x100, then SC 0x100 -> SW clears link. SC takes the SCFAIL path: no ramWEN, dwait=0 one cycle after arbitration, dload=0.
- In DSERVE, ramstate=ERROR for 3 cycles then ACCESS -> RAM outputs stable throughout, exactly one dwait=0 pulse. Separately, nRST low mid-DSERVE -> ramREN/ramWEN drop immediately and link_valid=0.
